// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state type and write-request record for the main-memory write port.
package mem_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic {IDLE, CLEAR} arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic. MEM_ARB_RR_EN selects round-robin on ties; otherwise requester 0
// has fixed priority.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

`ifdef MEM_ARB_RR_EN
    // last_q==1 means requester 1 was granted most recently, so requester 0 wins the next tie
    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = last_q ? 2'b01 : 2'b10;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (|grant_o) begin
            last_d = grant_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            grant_o = {valid_i[1] & ~valid_i[0], valid_i[0]};
        end
    end

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: rtl/mem_write_arbiter.sv
// Owns the 16x8 memory write port: arbitrates two requesters and runs the clear sweep.
// Build option MEM_ARB_RR_EN enables round-robin tie breaking inside rr_arbiter2.
module mem_write_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    arb_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    wr_req_t           issue_q;
    logic              issue_vld_q;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic [1:0]        grant;
    logic              accept;
    wr_req_t           sel_req;

    // Requests are only taken in IDLE when no clear is being launched; held off while in reset
    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .valid_i  ({req1_valid, req0_valid}),
        .enable_i (reset && (state_q == IDLE) && !clr_start),
        .grant_o  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign sel_req    = grant[1] ? '{addr: req1_addr, data: req1_data}
                                 : '{addr: req0_addr, data: req0_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            issue_q     <= '0;
            issue_vld_q <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q     <= CLEAR;
                        cnt_q       <= '0;
                        clr_busy_q  <= 1'b1;
                        issue_vld_q <= 1'b1;
                        issue_q     <= '{addr: '0, data: CLR_VALUE};
                    end else begin
                        issue_vld_q <= accept;
                        if (accept) begin
                            issue_q <= sel_req;
                        end
                    end
                end
                CLEAR: begin
                    // issue_q.addr tracks the counter so the port shows the word being cleared
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q     <= IDLE;
                        clr_busy_q  <= 1'b0;
                        clr_done_q  <= 1'b1;
                        issue_vld_q <= 1'b0;
                    end else begin
                        issue_q.addr <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem_we    = issue_vld_q;
    assign mem_waddr = issue_q.addr;
    assign mem_wdata = issue_q.data;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: queue-based port model checked every cycle plus directed scenarios.
module tb_mem_write_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid;
    logic [3:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: writes waiting for the port, one shown per cycle ----------------
    typedef struct packed {
        logic       sweep;
        logic [3:0] addr;
        logic [7:0] data;
    } mw_t;

    mw_t        wq[$];
    mw_t        cur;
    bit         cur_v;
    bit         m_done;
`ifdef MEM_ARB_RR_EN
    bit         m_last;
`endif
    logic [7:0] refmem [16];
    logic [7:0] tbmem  [16];

    function automatic int exp_grant();
        if (!reset || (cur_v && cur.sweep) || clr_start) return -1;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_RR_EN
            return m_last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wq.delete();
            cur_v  = 1'b0;
            cur    = '0;
            m_done = 1'b0;
`ifdef MEM_ARB_RR_EN
            m_last = 1'b1;
`endif
        end else begin
            int  mg;
            bit  idle;
            mg   = exp_grant();
            idle = !(cur_v && cur.sweep);
            if (mg == 0) wq.push_back('{sweep: 1'b0, addr: req0_addr, data: req0_data});
            if (mg == 1) wq.push_back('{sweep: 1'b0, addr: req1_addr, data: req1_data});
`ifdef MEM_ARB_RR_EN
            if (mg >= 0) m_last = mg[0];
`endif
            if (idle && clr_start) begin
                for (int a = 0; a < 16; a++) wq.push_back('{sweep: 1'b1, addr: a[3:0], data: 8'h00});
            end
            m_done = cur_v && cur.sweep && (cur.addr == 4'd15);
            if (cur_v) refmem[cur.addr] = cur.data;
            if (wq.size() > 0) begin
                cur   = wq.pop_front();
                cur_v = 1'b1;
            end else begin
                cur_v = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && mem_we) tbmem[mem_waddr] <= mem_wdata;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int cg;
        if (!reset) begin
            check("rst_we", mem_we, 0);
            check("rst_waddr", mem_waddr, 0);
            check("rst_wdata", mem_wdata, 0);
            check("rst_busy", clr_busy, 0);
            check("rst_done", clr_done, 0);
            check("rst_ready", {req1_ready, req0_ready}, 0);
        end else begin
            cg = exp_grant();
            check("ready0", req0_ready, cg == 0);
            check("ready1", req1_ready, cg == 1);
            check("we", mem_we, cur_v);
            if (cur_v) begin
                check("waddr", mem_waddr, cur.addr);
                check("wdata", mem_wdata, cur.data);
            end
            check("busy", clr_busy, cur_v && cur.sweep);
            check("done", clr_done, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0] gseq [4];
        int busy_n, done_n, wr_n, ok_n, found;

        reset = 1'b0; clr_start = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // 1: reset mid-traffic, then a single req0 write
        req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 8'h44;
        repeat (3) tick();
        reset = 1'b0; req0_valid = 1'b0;
        #1;
        check("t1_rst_we", mem_we, 0);
        check("t1_rst_addr_data", {mem_waddr, mem_wdata}, 0);
        check("t1_rst_flags", {clr_busy, clr_done, req0_ready, req1_ready}, 0);
        tick();
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'h5A;
        @(negedge clk);
        check("t1_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_issue", {mem_we, mem_waddr, mem_wdata}, {1'b1, 4'd3, 8'h5A});
        tick();

        // lone req1 write so requester 1 was granted last
        req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 8'h99;
        tick();
        req1_valid = 1'b0;
        tick();

        // 2: both valid for 4 cycles
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gseq[k] = {req1_ready, req0_ready};
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
        check("t2_g0", gseq[0], 2'b01);
        check("t2_g1", gseq[1], 2'b10);
        check("t2_g2", gseq[2], 2'b01);
        check("t2_g3", gseq[3], 2'b10);
`else
        check("t2_g0", gseq[0], 2'b01);
        check("t2_g1", gseq[1], 2'b01);
        check("t2_g2", gseq[2], 2'b01);
        check("t2_g3", gseq[3], 2'b01);
`endif
        repeat (2) tick();

        // 3: full clear sweep
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_n = 0; done_n = 0; ok_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (clr_busy) begin
                busy_n++;
                if (mem_we && mem_waddr == c[3:0] && mem_wdata == 8'h00) ok_n++;
            end
            if (clr_done) begin
                done_n++;
                check("t3_done_cycle", c, 16);
            end
            tick();
        end
        check("t3_busy_cycles", busy_n, 16);
        check("t3_sweep_writes", ok_n, 16);
        check("t3_done_pulses", done_n, 1);
        for (int a = 0; a < 16; a++) check("t3_readback", tbmem[a], 8'h00);

        // 4: accepted write just before clr_start issues first; stalled req0 served at clr_done
        req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 8'hC3;
        @(negedge clk);
        check("t4_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0; clr_start = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 8'h55;
        @(negedge clk);
        check("t4_first_issue", {mem_we, mem_waddr, mem_wdata}, {1'b1, 4'd7, 8'hC3});
        check("t4_no_ready_start", req0_ready, 0);
        tick();
        clr_start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (clr_done) begin
                found = 1;
                check("t4_ready0_at_done", req0_ready, 1);
            end else begin
                tick();
            end
        end
        check("t4_done_seen", found, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t4_req0_issue", {mem_we, mem_waddr, mem_wdata}, {1'b1, 4'd5, 8'h55});
        check("t4_addr7_cleared", tbmem[7], 8'h00);
        repeat (2) tick();

        // 5a: clr_start re-pulsed at sweep cycle 5 is ignored
        clr_start = 1'b1;
        tick();
        busy_n = 0; done_n = 0; wr_n = 0;
        for (int c = 0; c < 24; c++) begin
            clr_start = (c == 5);
            @(negedge clk);
            if (clr_busy) busy_n++;
            if (mem_we) wr_n++;
            if (clr_done) done_n++;
            tick();
        end
        clr_start = 1'b0;
        check("t5_busy_cycles", busy_n, 16);
        check("t5_writes", wr_n, 16);
        check("t5_done_pulses", done_n, 1);

        // 5b: reset at sweep cycle 8 aborts without clr_done
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        #1;
        check("t5_abort_we", mem_we, 0);
        check("t5_abort_busy", clr_busy, 0);
        tick();
        reset = 1'b1;
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (clr_done) done_n++;
            if (clr_busy) busy_n++;
            tick();
        end
        check("t5_abort_no_done", done_n, 0);
        check("t5_abort_no_busy", busy_n, 0);

        // 6: back-to-back single requester
        ok_n = 0;
        for (int i = 0; i < 10; i++) begin
            req0_valid = (i < 8);
            req0_addr  = i[3:0];
            req0_data  = 8'hA0 + i[7:0];
            @(negedge clk);
            if (i >= 1 && i <= 8 && mem_we && mem_waddr == 4'(i - 1) && mem_wdata == 8'hA0 + 8'(i - 1))
                ok_n++;
            tick();
        end
        req0_valid = 1'b0;
        check("t6_back_to_back", ok_n, 8);
        repeat (2) tick();

        for (int a = 0; a < 16; a++) check("final_mem", tbmem[a], refmem[a]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
